// File: rtl/encoder_16b20b.sv
// encoder_16b20b: 16-bit word plus two K flags to a 20-bit code group.
// The output is two chained 8b/10b symbols that share one running disparity.
// Lane 0 (Din[15:8]) is encoded first, starting from the registered rd.
// Lane 1 (Din[7:0]) is encoded from the RD that leaves lane 0.
// The RD that leaves lane 1 becomes the next rd.
//
// Ports:
//   clk   clock; all registers update on the rising edge
//   rst   asynchronous active-high reset
//   Din   data word; lane 0 = Din[15:8], lane 1 = Din[7:0]
//   ki    K-character request; ki[0] = lane 0, ki[1] = lane 1
//   ena   register enable; while low, Dout/rd/kerr hold
//   Dout  code group; lane 0 = Dout[19:10], lane 1 = Dout[9:0]
//         Within each lane field, bit 0 = a and bit 9 = j.
//   rd    running disparity after the last encoded group (0 = RD-, 1 = RD+)
//   kerr  ki was set on a byte that is not a valid K code; bit n = lane n

// Single-lane 8b/10b encoder (purely combinational).
// The 6b and 4b tables hold the RD- column.
// The RD+ code is the complement when the sub-block is unbalanced or RD-selected.
module encoder_16b20b_lane (
    input  logic [7:0] data,
    input  logic       k,
    input  logic       rd_in,
    output logic [9:0] code,
    output logic       rd_out,
    output logic       kerr
);
    logic [4:0] x;
    logic [2:0] y;
    logic       k_valid;
    logic       k_use;
    logic       k28;
    logic [5:0] six_neg;
    logic       unbal6;
    logic       special6;
    logic [5:0] six;
    logic       rd_mid;
    logic [3:0] four_neg;
    logic       unbal4;
    logic       special4;
    logic       alt7;
    logic [3:0] four;
    logic [9:0] sym;

    assign x = data[4:0];
    assign y = data[7:5];

    assign k_valid = (x == 5'd28) || (data == 8'hF7) || (data == 8'hFB) ||
                     (data == 8'hFD) || (data == 8'hFE);
    // An illegal K request falls back to the D-code of the same byte.
    assign k_use = k & k_valid;
    assign kerr  = k & ~k_valid;
    assign k28   = k_use && (x == 5'd28);

    // 5b/6b sub-block, RD- column (abcdei, a in the MSB of six_neg).
    always_comb begin
        six_neg  = 6'b000000;
        unbal6   = 1'b0;
        special6 = 1'b0;
        case (x)
            5'd0:  begin six_neg = 6'b100111; unbal6 = 1'b1; end
            5'd1:  begin six_neg = 6'b011101; unbal6 = 1'b1; end
            5'd2:  begin six_neg = 6'b101101; unbal6 = 1'b1; end
            5'd3:  six_neg = 6'b110001;
            5'd4:  begin six_neg = 6'b110101; unbal6 = 1'b1; end
            5'd5:  six_neg = 6'b101001;
            5'd6:  six_neg = 6'b011001;
            5'd7:  begin six_neg = 6'b111000; special6 = 1'b1; end
            5'd8:  begin six_neg = 6'b111001; unbal6 = 1'b1; end
            5'd9:  six_neg = 6'b100101;
            5'd10: six_neg = 6'b010101;
            5'd11: six_neg = 6'b110100;
            5'd12: six_neg = 6'b001101;
            5'd13: six_neg = 6'b101100;
            5'd14: six_neg = 6'b011100;
            5'd15: begin six_neg = 6'b010111; unbal6 = 1'b1; end
            5'd16: begin six_neg = 6'b011011; unbal6 = 1'b1; end
            5'd17: six_neg = 6'b100011;
            5'd18: six_neg = 6'b010011;
            5'd19: six_neg = 6'b110010;
            5'd20: six_neg = 6'b001011;
            5'd21: six_neg = 6'b101010;
            5'd22: six_neg = 6'b011010;
            5'd23: begin six_neg = 6'b111010; unbal6 = 1'b1; end
            5'd24: begin six_neg = 6'b110011; unbal6 = 1'b1; end
            5'd25: six_neg = 6'b100110;
            5'd26: six_neg = 6'b010110;
            5'd27: begin six_neg = 6'b110110; unbal6 = 1'b1; end
            5'd28: six_neg = 6'b001110;
            5'd29: begin six_neg = 6'b101110; unbal6 = 1'b1; end
            5'd30: begin six_neg = 6'b011110; unbal6 = 1'b1; end
            5'd31: begin six_neg = 6'b101011; unbal6 = 1'b1; end
            default: six_neg = 6'b000000;
        endcase
        if (k28) begin
            six_neg  = 6'b001111;
            unbal6   = 1'b1;
            special6 = 1'b0;
        end
    end

    assign six    = (rd_in && (unbal6 || special6)) ? ~six_neg : six_neg;
    assign rd_mid = rd_in ^ unbal6;

    // 3b/4b sub-block, encoded with the RD left by the 6b sub-block.
    // The alternate x.7 avoids a run of five equal bits across the sub-block boundary.
    assign alt7 = (y == 3'd7) &&
                  (k_use ||
                   (!rd_mid && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
                   ( rd_mid && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14))));

    always_comb begin
        four_neg = 4'b0000;
        unbal4   = 1'b0;
        special4 = 1'b0;
        case (y)
            3'd0: begin four_neg = 4'b1011; unbal4 = 1'b1; end
            3'd1: four_neg = 4'b1001;
            3'd2: four_neg = 4'b0101;
            3'd3: begin four_neg = 4'b1100; special4 = 1'b1; end
            3'd4: begin four_neg = 4'b1101; unbal4 = 1'b1; end
            3'd5: four_neg = 4'b1010;
            3'd6: four_neg = 4'b0110;
            3'd7: begin four_neg = alt7 ? 4'b0111 : 4'b1110; unbal4 = 1'b1; end
            default: four_neg = 4'b0000;
        endcase
        // For K28.1/.2/.5/.6, the balanced 4b code is RD-selected.
        // The RD- form is the complement of the D form.
        if (k28 && (y == 3'd1 || y == 3'd2 || y == 3'd5 || y == 3'd6)) begin
            four_neg = ~four_neg;
            special4 = 1'b1;
        end
    end

    assign four   = (rd_mid && (unbal4 || special4)) ? ~four_neg : four_neg;
    assign rd_out = rd_mid ^ unbal4;

    // Transmission order abcdei fghj, with a in bit 0 of the lane field.
    assign sym = {six, four};
    always_comb begin
        code = 10'd0;
        for (int i = 0; i < 10; i++) begin
            code[i] = sym[9-i];
        end
    end
endmodule

module encoder_16b20b #(
    parameter int DIN  = 16,
    parameter int DOUT = 20
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DIN-1:0]  Din,
    input  logic [1:0]      ki,
    input  logic            ena,
    output logic [DOUT-1:0] Dout,
    output logic            rd,
    output logic [1:0]      kerr
);
    logic [9:0] code0;
    logic [9:0] code1;
    logic       rd0;
    logic       rd1;
    logic       kerr0;
    logic       kerr1;

    encoder_16b20b_lane u_lane0 (
        .data   (Din[15:8]),
        .k      (ki[0]),
        .rd_in  (rd),
        .code   (code0),
        .rd_out (rd0),
        .kerr   (kerr0)
    );

    encoder_16b20b_lane u_lane1 (
        .data   (Din[7:0]),
        .k      (ki[1]),
        .rd_in  (rd0),
        .code   (code1),
        .rd_out (rd1),
        .kerr   (kerr1)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Dout <= '0;
            rd   <= 1'b0;
            kerr <= 2'b00;
        end else if (ena) begin
            Dout <= {code0, code1};
            rd   <= rd1;
            kerr <= {kerr1, kerr0};
        end
    end
endmodule

// File: tb/tb_encoder_16b20b.sv
module tb_encoder_16b20b;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] Din = '0;
    logic [1:0]  ki = '0;
    logic        ena = 1'b0;
    logic [19:0] Dout;
    logic        rd;
    logic [1:0]  kerr;

    int n_checks = 0;
    int n_fail   = 0;

    encoder_16b20b dut (
        .clk  (clk),
        .rst  (rst),
        .Din  (Din),
        .ki   (ki),
        .ena  (ena),
        .Dout (Dout),
        .rd   (rd),
        .kerr (kerr)
    );

    always #5 clk = ~clk;

    // Code tables written as the RD- and RD+ columns of the standard.
    // Each entry is in transmission order, with a or f as the leftmost bit.
    localparam logic [5:0] T6N [0:31] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
    localparam logic [5:0] T6P [0:31] = '{
        6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
        6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
        6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
        6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
    localparam logic [3:0] T4N [0:7] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100,
                                         4'b1101, 4'b1010, 4'b0110, 4'b1110};
    localparam logic [3:0] T4P [0:7] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011,
                                         4'b0010, 4'b1010, 4'b0110, 4'b0001};
    localparam logic [3:0] K4N [0:7] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100,
                                         4'b1101, 4'b0101, 4'b1001, 4'b0111};
    localparam logic [3:0] K4P [0:7] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011,
                                         4'b0010, 4'b1010, 4'b0110, 4'b1000};
    localparam logic [7:0] KLIST [0:11] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC,
                                            8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE};

    // Disparity after a sub-block of width w:
    // more ones gives RD+, fewer ones gives RD-, and an equal count keeps the RD.
    function automatic logic rd_after(input logic rdi, input int ones, input int w);
        if (2 * ones > w) return 1'b1;
        if (2 * ones < w) return 1'b0;
        return rdi;
    endfunction

    function automatic void enc_model(input logic [7:0] b, input logic k, input logic rdi,
                                      output logic [9:0] code, output logic rdo,
                                      output logic ke);
        int         x;
        int         y;
        logic       valid;
        logic       kv;
        logic       rdm;
        logic [5:0] s6;
        logic [3:0] s4;
        logic [9:0] s;
        x = int'(b[4:0]);
        y = int'(b[7:5]);
        valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (KLIST[i] == b) valid = 1'b1;
        end
        kv = k && valid;
        ke = k && !valid;
        if (kv && x == 28) s6 = rdi ? 6'b110000 : 6'b001111;
        else               s6 = rdi ? T6P[x] : T6N[x];
        rdm = rd_after(rdi, $countones(s6), 6);
        if (kv && x == 28)
            s4 = rdm ? K4P[y] : K4N[y];
        else if (y == 7 && (kv || (!rdm && (x == 17 || x == 18 || x == 20)) ||
                            (rdm && (x == 11 || x == 13 || x == 14))))
            s4 = rdm ? 4'b1000 : 4'b0111;
        else
            s4 = rdm ? T4P[y] : T4N[y];
        rdo = rd_after(rdm, $countones(s4), 4);
        s = {s6, s4};
        for (int i = 0; i < 10; i++) code[i] = s[9-i];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference state, following the same clock/reset as the DUT.
    logic [19:0] m_dout = '0;
    logic        m_rd = 1'b0;
    logic [1:0]  m_kerr = '0;

    always @(posedge clk or posedge rst) begin
        logic [9:0] c0;
        logic [9:0] c1;
        logic       r0;
        logic       r1;
        logic       e0;
        logic       e1;
        if (rst) begin
            m_dout = '0;
            m_rd   = 1'b0;
            m_kerr = '0;
        end else if (ena) begin
            enc_model(Din[15:8], ki[0], m_rd, c0, r0, e0);
            enc_model(Din[7:0],  ki[1], r0,   c1, r1, e1);
            m_dout = {c0, c1};
            m_rd   = r1;
            m_kerr = {e1, e0};
        end
    end

    always @(negedge clk) begin
        chk("model Dout", 32'(Dout), 32'(m_dout));
        chk("model rd",   32'(rd),   32'(m_rd));
        chk("model kerr", 32'(kerr), 32'(m_kerr));
    end

    task automatic drive(input logic [15:0] d, input logic [1:0] k, input logic e);
        @(negedge clk);
        Din = d;
        ki  = k;
        ena = e;
    endtask

    task automatic group(input logic [15:0] d, input logic [1:0] k, input string name,
                         input logic [19:0] exp_dout, input logic exp_rd,
                         input logic [1:0] exp_kerr);
        drive(d, k, 1'b1);
        @(posedge clk);
        #1;
        chk({name, " Dout"}, 32'(Dout), 32'(exp_dout));
        chk({name, " rd"},   32'(rd),   32'(exp_rd));
        chk({name, " kerr"}, 32'(kerr), 32'(exp_kerr));
    endtask

    function automatic void rand_sym(output logic [7:0] b, output logic k);
        int r;
        r = $urandom_range(0, 9);
        if (r < 3) begin
            k = 1'b1;
            b = KLIST[$urandom_range(0, 11)];
        end else if (r == 3) begin
            k = 1'b1;
            b = 8'($urandom);
        end else begin
            k = 1'b0;
            b = 8'($urandom);
        end
    endfunction

    initial begin
        logic [9:0] mc;
        logic       mr;
        logic       me;
        logic [7:0] b0;
        logic [7:0] b1;
        logic       k0;
        logic       k1;

        // Pin the model itself with hand-derived code words.
        enc_model(8'hBC, 1'b1, 1'b0, mc, mr, me);
        chk("pin K28.5 RD- code", 32'(mc), 32'h17C);
        chk("pin K28.5 RD- rd", 32'(mr), 32'h1);
        enc_model(8'hBC, 1'b1, 1'b1, mc, mr, me);
        chk("pin K28.5 RD+ code", 32'(mc), 32'h283);
        enc_model(8'hB5, 1'b0, 1'b1, mc, mr, me);
        chk("pin D21.5 RD+ code", 32'(mc), 32'h155);
        enc_model(8'h00, 1'b0, 1'b0, mc, mr, me);
        chk("pin D0.0 RD- code", 32'(mc), 32'h0B9);
        enc_model(8'h00, 1'b1, 1'b0, mc, mr, me);
        chk("pin illegal K flag", 32'(me), 32'h1);

        // Reset with arbitrary inputs, then release while ena stays low.
        #1 rst = 1'b1;
        Din = 16'hA5C3;
        ki  = 2'b11;
        ena = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset Dout", 32'(Dout), 32'h0);
        chk("reset rd",   32'(rd),   32'h0);
        chk("reset kerr", 32'(kerr), 32'h0);
        @(negedge clk);
        ena = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle Dout", 32'(Dout), 32'h0);
        chk("idle rd",   32'(rd),   32'h0);

        group(16'hBCBC, 2'b11, "comma pair",  20'h5F283, 1'b0, 2'b00);
        group(16'hB5B5, 2'b00, "D21.5 RD-",   20'h55555, 1'b0, 2'b00);
        group(16'hBCB5, 2'b01, "preload RD+", 20'h5F155, 1'b1, 2'b00);
        group(16'hB5B5, 2'b00, "D21.5 RD+",   20'h55555, 1'b1, 2'b00);
        group(16'hBCB5, 2'b01, "K28.5 RD+",   20'hA0D55, 1'b0, 2'b00);
        group(16'h0000, 2'b00, "D0.0",        20'h2E4B9, 1'b0, 2'b00);
        group(16'h0000, 2'b01, "illegal K",   20'h2E4B9, 1'b0, 2'b01);
        group(16'h0000, 2'b00, "kerr clear",  20'h2E4B9, 1'b0, 2'b00);

        // Sweep every D and K code through both lanes, against random neighbours.
        for (int pass = 0; pass < 4; pass++) begin
            for (int i = 0; i < 268; i++) begin
                b0 = (i < 256) ? 8'(i) : KLIST[i-256];
                k0 = (i >= 256);
                rand_sym(b1, k1);
                if (pass < 2) drive({b0, b1}, {k1, k0}, 1'b1);
                else          drive({b1, b0}, {k0, k1}, 1'b1);
            end
        end

        // Random stream with enable gaps, a 3-cycle hold and an async reset pulse.
        for (int n = 0; n < 300; n++) begin
            rand_sym(b0, k0);
            rand_sym(b1, k1);
            if (n >= 150 && n < 153)
                drive({b0, b1}, {k1, k0}, 1'b0);
            else
                drive({b0, b1}, {k1, k0}, ($urandom_range(0, 9) < 8));
            if (n == 220) begin
                #1 rst = 1'b1;
                #1;
                chk("async rst Dout", 32'(Dout), 32'h0);
                chk("async rst rd",   32'(rd),   32'h0);
                chk("async rst kerr", 32'(kerr), 32'h0);
                #1 rst = 1'b0;
            end
        end

        drive(16'h0000, 2'b00, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
